operand_issue: RTL

Front half of the execute pipeline: accepts one 9-bit instruction per cycle over a valid/ready handshake, decodes it, reads the 8×8 register file and registers the ALU controls and operands into an issue register that drives the ALU directly. The ALU result returns combinationally on `Rslt`. It is written back into the register file at the end of the issue cycle, with forwarding to the instruction being decoded in that same cycle.

---
 rtl/issue_pkg.sv | 36 +++
 rtl/reg_file.sv | 35 +++
 rtl/operand_issue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// Shared definitions for the operand issue stage: opcodes, instruction
// field positions and the issue-register layout.
package issue_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    localparam int F_LDC     = 8;
    localparam int F_OP_HI   = 7;
    localparam int F_OP_LO   = 5;
    localparam int F_RA_HI   = 4;
    localparam int F_RA_LO   = 2;
    localparam int F_RB_HI   = 1;
    localparam int F_RB_LO   = 0;
    localparam int F_LDCV_HI = 4;
    localparam int F_LDCV_LO = 0;

    typedef struct packed {
        logic              valid;
        logic              ldcen;
        logic [2:0]        aluop;
        logic [4:0]        ldcval;
        logic [2:0]        rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] datb;
    } iss_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// synchronous clear on reset.
module reg_file #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NREG];

    // Storage update: reset clears every entry and wins over a pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/operand_issue.sv
// Decode, operand read and issue register feeding the ALU.
// Build option: OPERAND_FORWARD_EN selects forwarding instead of a hazard stall.
module operand_issue
    import issue_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [8:0]    Instr,
    input  logic          Hold,
    output logic          IssValid,
    output logic          Ldcen,
    output logic [2:0]    Aluop,
    output logic [4:0]    LdcVal,
    output logic [DW-1:0] DatA,
    output logic [DW-1:0] DatB,
    input  logic [DW-1:0] Rslt
);

    iss_t          iss_q;
    iss_t          iss_d;
    logic          dec_ldc_s;
    logic [2:0]    ra_s;
    logic [2:0]    rb_s;
    logic [2:0]    rd_s;
    logic [DW-1:0] rf_a_s;
    logic [DW-1:0] rf_b_s;
    logic [DW-1:0] opa_s;
    logic [DW-1:0] opb_s;
    logic          wb_en_s;
    logic          hazard_s;
    logic          accept_s;

    assign wb_en_s = iss_q.valid & ~Hold;

    reg_file #(.DW(DW), .NREG(NREG)) u_reg_file (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .we_i      (wb_en_s),
        .waddr_i   (iss_q.rd),
        .wdata_i   (Rslt),
        .raddr_a_i (ra_s),
        .rdata_a_o (rf_a_s),
        .raddr_b_i (rb_s),
        .rdata_b_o (rf_b_s)
    );

    // Instruction field decode; ALU ops use the same register as source A and destination.
    always_comb begin
        dec_ldc_s = Instr[F_LDC];
        ra_s      = Instr[F_RA_HI:F_RA_LO];
        rb_s      = {1'b0, Instr[F_RB_HI:F_RB_LO]};
        if (dec_ldc_s) begin
            rd_s = Instr[F_OP_HI:F_OP_LO];
        end else begin
            rd_s = Instr[F_RA_HI:F_RA_LO];
        end
    end

    // Operand select: bypass the result being written this cycle, or stall on a RAW hazard.
    always_comb begin
`ifdef OPERAND_FORWARD_EN
        if (wb_en_s && (ra_s == iss_q.rd)) begin
            opa_s = Rslt;
        end else begin
            opa_s = rf_a_s;
        end
        if (wb_en_s && (rb_s == iss_q.rd)) begin
            opb_s = Rslt;
        end else begin
            opb_s = rf_b_s;
        end
        hazard_s = 1'b0;
`else
        opa_s    = rf_a_s;
        opb_s    = rf_b_s;
        hazard_s = iss_q.valid & ~dec_ldc_s &
                   ((ra_s == iss_q.rd) | (rb_s == iss_q.rd));
`endif
    end

    // Reset keeps the port ready but nothing presented then is taken.
    assign InReady  = Reset | (~Hold & ~hazard_s);
    assign accept_s = InValid & InReady & ~Reset;

    // Next issue-register contents: decoded instruction or an all-zero bubble.
    always_comb begin
        iss_d = '0;
        if (accept_s) begin
            iss_d.valid = 1'b1;
            iss_d.ldcen = dec_ldc_s;
            iss_d.rd    = rd_s;
            if (dec_ldc_s) begin
                iss_d.aluop  = OP_AND;
                iss_d.ldcval = Instr[F_LDCV_HI:F_LDCV_LO];
            end else begin
                iss_d.aluop = Instr[F_OP_HI:F_OP_LO];
                iss_d.data  = opa_s;
                iss_d.datb  = opb_s;
            end
        end else begin
            iss_d.valid = 1'b0;
        end
    end

    // Issue register: frozen while Hold is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            iss_q <= '0;
        end else if (!Hold) begin
            iss_q <= iss_d;
        end
    end

    assign IssValid = iss_q.valid;
    assign Ldcen    = iss_q.ldcen;
    assign Aluop    = iss_q.aluop;
    assign LdcVal   = iss_q.ldcval;
    assign DatA     = iss_q.data;
    assign DatB     = iss_q.datb;

endmodule
